barrel_shift_sequencer: RTL and testbench



---
 rtl/barrel_shift_sequencer.sv | 137 +++++++++++++
 tb/tb_barrel_shift_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_sequencer.sv
// Multi-cycle shift controller iterating a 4-bit logical barrel shifter over a wide shift amount.
// Optional macro SEQ_FASTPATH_EN: amounts >= 4 skip iteration and complete with a zero result.

module barrel_shifter_4bit (
  input  logic [3:0] A,
  input  logic [1:0] sel,
  input  logic       dir,
  output logic [3:0] out
);
  always_comb begin
    out = dir ? (A >> sel) : (A << sel);
  end
endmodule

// state | meaning
// IDLE  | ready for a command, accumulator holds the last result
// SHIFT | applying up to STEP_MAX bits per cycle until rem reaches zero
// DONE  | result presented, waiting for out_ready
module barrel_shift_sequencer #(
  parameter int AMT_W    = 4,
  parameter int STEP_MAX = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             busy
);

  if (STEP_MAX < 1 || STEP_MAX > 3) begin : g_bad_step
    $error("barrel_shift_sequencer: STEP_MAX must be 1..3");
  end
  if (AMT_W < 2) begin : g_bad_amt
    $error("barrel_shift_sequencer: AMT_W must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [AMT_W-1:0] STEP_L = AMT_W'(STEP_MAX);

  state_t           state_q, state_d;
  logic [3:0]       acc_q, acc_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic [AMT_W-1:0] step;
  logic [3:0]       shf_out;
  logic             accept;

  assign accept = in_valid && (state_q == IDLE);

  // step never exceeds rem, so rem - step cannot wrap
  always_comb begin
    step = (rem_q < STEP_L) ? rem_q : STEP_L;
  end

  barrel_shifter_4bit u_shifter (
    .A   (acc_q),
    .sel (step[1:0]),
    .dir (dir_q),
    .out (shf_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= 4'd0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          dir_d = in_dir;
`ifdef SEQ_FASTPATH_EN
          if (in_amt > AMT_W'(3)) begin
            acc_d   = 4'd0;
            rem_d   = '0;
            state_d = DONE;
          end else begin
            acc_d   = in_data;
            rem_d   = in_amt;
            state_d = SHIFT;
          end
`else
          acc_d   = in_data;
          rem_d   = in_amt;
          state_d = SHIFT;
`endif
        end
      end
      SHIFT: begin
        acc_d = shf_out;
        rem_d = rem_q - step;
        // rem == 0 gives step == 0, so this also covers the zero-amount case
        if (rem_q == step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_data  = acc_q;
  end

endmodule

// File: tb/tb_barrel_shift_sequencer.sv
// Bench for barrel_shift_sequencer: one instance with STEP_MAX=3 (u=0) and one with STEP_MAX=1 (u=1).
module tb_barrel_shift_sequencer;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [1:0]      in_valid = '0;
  logic [1:0]      in_ready;
  logic [1:0][3:0] in_data = '0;
  logic [1:0][3:0] in_amt = '0;
  logic [1:0]      in_dir = '0;
  logic [1:0]      out_valid;
  logic [1:0]      out_ready = '0;
  logic [1:0][3:0] out_data;
  logic [1:0]      busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  barrel_shift_sequencer #(.AMT_W(4), .STEP_MAX(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_amt(in_amt[0]), .in_dir(in_dir[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0])
  );

  barrel_shift_sequencer #(.AMT_W(4), .STEP_MAX(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_amt(in_amt[1]), .in_dir(in_dir[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: logical shift with zero fill on a 4-bit word
  function automatic logic [3:0] ref_shift(input logic [3:0] d, input int amt, input logic dir);
    int v;
    v = d;
    if (dir) v = v >> amt;
    else     v = (v << amt) & 15;
    return 4'(v);
  endfunction

  function automatic int ref_lat(input int u, input int amt);
    int smax;
    smax = (u == 0) ? 3 : 1;
`ifdef SEQ_FASTPATH_EN
    if (amt >= 4) return 0;
`endif
    if (amt == 0) return 1;
    return (amt + smax - 1) / smax;
  endfunction

  task automatic check_reset_vals(input string tag);
    for (int u = 0; u < 2; u++) begin
      check({tag, "_in_ready"},  32'(in_ready[u]),  32'd1);
      check({tag, "_out_valid"}, 32'(out_valid[u]), 32'd0);
      check({tag, "_out_data"},  32'(out_data[u]),  32'd0);
      check({tag, "_busy"},      32'(busy[u]),      32'd0);
    end
  endtask

  // Called at a negedge with the addressed instance idle; returns at a negedge, idle again.
  task automatic do_cmd(input int u, input logic [3:0] d, input logic [3:0] amt,
                        input logic dir, input int hold, input string tag);
    int lat;
    logic [3:0] exp_d;
    exp_d = ref_shift(d, int'(amt), dir);
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    in_amt[u]   = amt;
    in_dir[u]   = dir;
    check({tag, "_in_ready"}, 32'(in_ready[u]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[u] = 1'b0;
    in_data[u]  = 4'($urandom);
    in_amt[u]   = 4'($urandom);
    in_dir[u]   = 1'($urandom);
    lat = 0;
    @(negedge clk);
    while (!out_valid[u] && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_timeout"}, 32'(lat < 40), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(ref_lat(u, int'(amt))));
    check({tag, "_data"}, 32'(out_data[u]), 32'(exp_d));
    repeat (hold) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(out_valid[u]), 32'd1);
      check({tag, "_hold_data"}, 32'(out_data[u]), 32'(exp_d));
    end
    out_ready[u] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[u] = 1'b0;
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(out_valid[u]), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready[u]), 32'd1);
  endtask

  initial begin
    logic [3:0] exp_d;
    int cnt;

    // Reset asserted mid-clock; outputs must respond without an edge
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // STEP_MAX = 3 directed
    do_cmd(0, 4'b1011, 4'd1, 1'b0, 0, "t2_l1");
    do_cmd(0, 4'b1011, 4'd2, 1'b1, 0, "t2_r2");
    do_cmd(0, 4'b1011, 4'd0, 1'b0, 0, "t2_z");

    // STEP_MAX = 1: watch each intermediate accumulator value
    in_valid[1] = 1'b1;
    in_data[1]  = 4'b0001;
    in_amt[1]   = 4'd3;
    in_dir[1]   = 1'b0;
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    @(negedge clk);
    check("t3_busy", 32'(busy[1]), 32'd1);
    check("t3_acc0", 32'(out_data[1]), 32'b0001);
    @(negedge clk);
    check("t3_acc1", 32'(out_data[1]), 32'b0010);
    check("t3_nv1", 32'(out_valid[1]), 32'd0);
    @(negedge clk);
    check("t3_acc2", 32'(out_data[1]), 32'b0100);
    check("t3_nv2", 32'(out_valid[1]), 32'd0);
    @(negedge clk);
    check("t3_acc3", 32'(out_data[1]), 32'b1000);
    check("t3_valid", 32'(out_valid[1]), 32'd1);
    out_ready[1] = 1'b1;
    @(negedge clk);
    out_ready[1] = 1'b0;
    check("t3_drop", 32'(out_valid[1]), 32'd0);

    // Right shift by 7 in steps 3,3,1
    do_cmd(0, 4'b1111, 4'd7, 1'b1, 0, "t4");

    // Backpressure with a competing command held on the input
    in_valid[0] = 1'b1;
    in_data[0]  = 4'b0011;
    in_amt[0]   = 4'd2;
    in_dir[0]   = 1'b0;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    cnt = 0;
    @(negedge clk);
    while (!out_valid[0] && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("t5_timeout", 32'(cnt < 40), 32'd1);
    in_valid[0] = 1'b1;
    in_data[0]  = 4'b0101;
    in_amt[0]   = 4'd1;
    in_dir[0]   = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t5_data", 32'(out_data[0]), 32'b1100);
      check("t5_valid", 32'(out_valid[0]), 32'd1);
      check("t5_in_ready", 32'(in_ready[0]), 32'd0);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    @(negedge clk);
    check("t5_idle_ready", 32'(in_ready[0]), 32'd1);
    check("t5_idle_valid", 32'(out_valid[0]), 32'd0);
    check("t5_idle_busy", 32'(busy[0]), 32'd0);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("t5_new_busy", 32'(busy[0]), 32'd1);
    cnt = 0;
    while (!out_valid[0] && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("t5_new_data", 32'(out_data[0]), 32'b0010);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;

    // Reset in the middle of a long command
    in_valid[0] = 1'b1;
    in_data[0]  = 4'b1001;
    in_amt[0]   = 4'd9;
    in_dir[0]   = 1'b0;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid[0]) cnt++;
    end
    check("t6_no_valid", 32'(cnt), 32'd0);
    do_cmd(0, 4'b0100, 4'd1, 1'b0, 0, "t6_post");

    // Randomized commands against the reference model
    for (int i = 0; i < 40; i++) begin
      do_cmd(int'($urandom_range(0, 1)), 4'($urandom), 4'($urandom_range(0, 15)),
             1'($urandom), int'($urandom_range(0, 3)), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
